// File: rtl/range_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : range_scan_ctrl_pkg
// Description : Shared constants, FSM state encoding and decimal helper
//               functions for the range scan controller.
// Revision    : 1.0 - initial release
// ============================================================================
package range_scan_ctrl_pkg;

  localparam int DATA_WIDTH      = 32;
  localparam int LONG_DATA_WIDTH = 64;
  localparam int MAX_DIGS        = 10;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DIGS  = 3'd1,
    S_CHECK = 3'd2,
    S_NEXT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // 10^e at full accumulator width; e beyond 19 would overflow 64 bits.
  function automatic logic [LONG_DATA_WIDTH-1:0] pow10(input int e);
    logic [LONG_DATA_WIDTH-1:0] p;
    p = 1;
    for (int i = 0; i < 20; i++) begin
      if (i < e) p = p * 10;
    end
    return p;
  endfunction

  // Decimal digit count; zero is treated as a single digit.
  function automatic int count_digits(input logic [LONG_DATA_WIDTH-1:0] v);
    int d;
    d = 1;
    for (int i = 1; i < 20; i++) begin
      if (v >= pow10(i)) d = i + 1;
    end
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/range_scan_ctrl_group_match.sv
`default_nettype none
// ============================================================================
// Module      : group_match
// Description : Combinational test of whether n consists of k identical
//               decimal groups of digs/k digits each (no leading zero).
// Revision    : 1.0 - initial release
// ============================================================================
module group_match #(
  parameter int DATA_WIDTH      = range_scan_ctrl_pkg::DATA_WIDTH,
  parameter int LONG_DATA_WIDTH = range_scan_ctrl_pkg::LONG_DATA_WIDTH,
  parameter int MAX_DIGS        = range_scan_ctrl_pkg::MAX_DIGS,
  parameter int KW              = $clog2(MAX_DIGS + 1)
) (
  input  logic [DATA_WIDTH-1:0] n,
  input  logic [KW-1:0]         digs,
  input  logic [KW-1:0]         k,
  output logic                  match
);
  import range_scan_ctrl_pkg::*;

  logic [LONG_DATA_WIDTH-1:0] n_wide;
  logic [LONG_DATA_WIDTH-1:0] chunk;
  logic [LONG_DATA_WIDTH-1:0] rep;

  assign n_wide = LONG_DATA_WIDTH'(n);

  // Enumerate every legal (group length, group count) pair as constants so the
  // modulo and repunit become fixed; only the pair equal to (digs/k, k) fires.
  always_comb begin
    match = 1'b0;
    chunk = '0;
    rep   = '0;
    for (int len = 1; len <= MAX_DIGS; len++) begin
      for (int kk = 2; kk <= MAX_DIGS; kk++) begin
        if ((kk * len <= MAX_DIGS) && (int'(k) == kk) && (int'(digs) == kk * len)) begin
          chunk = n_wide % pow10(len);
          rep   = '0;
          for (int i = 0; i < MAX_DIGS; i++) begin
            if (i < kk) rep = rep + pow10(i * len);
          end
          if ((chunk >= pow10(len - 1)) && (n_wide == chunk * rep)) match = 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/range_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : range_scan_ctrl
// Description : Walks an ID range, time-sharing one group checker across the
//               candidate group counts, and returns sum/count of matches.
// Revision    : 1.0 - initial release
// ============================================================================
module range_scan_ctrl #(
  parameter int DATA_WIDTH      = range_scan_ctrl_pkg::DATA_WIDTH,
  parameter int LONG_DATA_WIDTH = range_scan_ctrl_pkg::LONG_DATA_WIDTH,
  parameter int MAX_DIGS        = range_scan_ctrl_pkg::MAX_DIGS,
  parameter int PART            = 1
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_WIDTH-1:0]      lo_in,
  input  logic [DATA_WIDTH-1:0]      hi_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LONG_DATA_WIDTH-1:0] sum_out,
  output logic [DATA_WIDTH-1:0]      count_out,
  output logic                       busy
);
  import range_scan_ctrl_pkg::*;

  localparam int KW = $clog2(MAX_DIGS + 1);

  state_t                     state;
  logic [DATA_WIDTH-1:0]      n;
  logic [DATA_WIDTH-1:0]      hi;
  logic [DATA_WIDTH-1:0]      count;
  logic [LONG_DATA_WIDTH-1:0] sum;
  logic [KW-1:0]              digs;
  logic [KW-1:0]              k;
  logic [KW-1:0]              limit;
  logic                       hit;
  logic                       match;

  group_match #(
    .DATA_WIDTH      (DATA_WIDTH),
    .LONG_DATA_WIDTH (LONG_DATA_WIDTH),
    .MAX_DIGS        (MAX_DIGS),
    .KW              (KW)
  ) u_group_match (
    .n     (n),
    .digs  (digs),
    .k     (k),
    .match (match)
  );

  // Last group count to try: only halves in part 1, every k up to digs in part 2.
  always_comb begin
    if (PART == 1)        limit = KW'(2);
    else if (digs < KW'(2)) limit = KW'(2);
    else                  limit = digs;
  end

  // Handshake and result outputs decode straight from registered state.
  assign in_ready  = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign out_valid = (state == S_DONE);
  assign sum_out   = sum;
  assign count_out = count;

  // Scan sequencer: accept range, per n compute digits, sweep k, accumulate.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      n     <= '0;
      hi    <= '0;
      sum   <= '0;
      count <= '0;
      digs  <= '0;
      k     <= '0;
      hit   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            n     <= lo_in;
            hi    <= hi_in;
            sum   <= '0;
            count <= '0;
            hit   <= 1'b0;
            state <= (lo_in <= hi_in) ? S_DIGS : S_DONE;
          end
        end
        S_DIGS: begin
          digs  <= KW'(count_digits(64'(n)));
          k     <= KW'(2);
          state <= S_CHECK;
        end
        S_CHECK: begin
          if (match) begin
            hit   <= 1'b1;
            state <= S_NEXT;
          end else if (k == limit) begin
            state <= S_NEXT;
          end else begin
            k <= k + 1'b1;
          end
        end
        S_NEXT: begin
          if (hit) begin
            sum   <= sum + LONG_DATA_WIDTH'(n);
            count <= count + 1'b1;
          end
          hit <= 1'b0;
          // Equality test ends the range so an all-ones hi never wraps n.
          if (n == hi) begin
            state <= S_DONE;
          end else begin
            n     <= n + 1'b1;
            state <= S_DIGS;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_range_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_range_scan_ctrl
// Description : Directed self-checking bench; a PART=1 and a PART=2 instance
//               share all inputs so each range exercises both variants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_range_scan_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] lo_in;
  logic [31:0] hi_in;

  logic        in_ready1, out_valid1, busy1;
  logic [63:0] sum1;
  logic [31:0] count1;
  logic        in_ready2, out_valid2, busy2;
  logic [63:0] sum2;
  logic [31:0] count2;

  int checks   = 0;
  int failures = 0;

  range_scan_ctrl #(.PART(1)) u_p1 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready1),
    .lo_in(lo_in), .hi_in(hi_in), .out_valid(out_valid1), .out_ready(out_ready),
    .sum_out(sum1), .count_out(count1), .busy(busy1)
  );

  range_scan_ctrl #(.PART(2)) u_p2 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready2),
    .lo_in(lo_in), .hi_in(hi_in), .out_valid(out_valid2), .out_ready(out_ready),
    .sum_out(sum2), .count_out(count2), .busy(busy2)
  );

  always #5 clock = ~clock;

  // Present a request for one edge; that edge is edge 0.
  task automatic start_req(input logic [31:0] lo, input logic [31:0] hi);
    in_valid = 1'b1;
    lo_in    = lo;
    hi_in    = hi;
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  // Edges after accept until each out_valid is seen; -1 if budget expires.
  task automatic wait_done(output int t1, output int t2);
    t1 = -1;
    t2 = -1;
    for (int c = 0; c < 4000; c++) begin
      if (out_valid1 && t1 < 0) t1 = c;
      if (out_valid2 && t2 < 0) t2 = c;
      if (t1 >= 0 && t2 >= 0) break;
      @(posedge clock); #1;
    end
  endtask

  task automatic consume;
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    checks++; if (out_valid1 !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid1); end
    checks++; if (in_ready1 !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready1); end
    checks++; if (busy2 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy2); end
    checks++; if (sum1 !== 64'd0 || count1 !== 32'd0) begin failures++; $display("FAIL reset_data got=%0d/%0d want=0/0", sum1, count1); end
  endtask

  task automatic test_basic_range;
    int t1, t2;
    start_req(32'd11, 32'd22);
    wait_done(t1, t2);
    checks++; if (t1 !== 36) begin failures++; $display("FAIL basic_latency_p1 got=%0d want=36", t1); end
    checks++; if (t2 !== 36) begin failures++; $display("FAIL basic_latency_p2 got=%0d want=36", t2); end
    checks++; if (sum1 !== 64'd33 || count1 !== 32'd2) begin failures++; $display("FAIL basic_p1 got=%0d/%0d want=33/2", sum1, count1); end
    checks++; if (sum2 !== 64'd33 || count2 !== 32'd2) begin failures++; $display("FAIL basic_p2 got=%0d/%0d want=33/2", sum2, count2); end
    consume();
    checks++; if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin failures++; $display("FAIL basic_consume got=%b%b want=01", out_valid1, in_ready1); end
  endtask

  task automatic test_mixed_range;
    int t1, t2;
    start_req(32'd95, 32'd115);
    wait_done(t1, t2);
    checks++; if (sum1 !== 64'd99 || count1 !== 32'd1) begin failures++; $display("FAIL mixed_p1 got=%0d/%0d want=99/1", sum1, count1); end
    checks++; if (sum2 !== 64'd210 || count2 !== 32'd2) begin failures++; $display("FAIL mixed_p2 got=%0d/%0d want=210/2", sum2, count2); end
    consume();
  endtask

  task automatic test_digit_boundary;
    int t1, t2;
    start_req(32'd998, 32'd1012);
    wait_done(t1, t2);
    checks++; if (sum1 !== 64'd1010 || count1 !== 32'd1) begin failures++; $display("FAIL boundary_p1 got=%0d/%0d want=1010/1", sum1, count1); end
    checks++; if (sum2 !== 64'd2009 || count2 !== 32'd2) begin failures++; $display("FAIL boundary_p2 got=%0d/%0d want=2009/2", sum2, count2); end
    consume();
    // 999 in part 2: k=2 misses, k=3 hits -> 1 + 2 + 1 edges.
    start_req(32'd999, 32'd999);
    wait_done(t1, t2);
    checks++; if (t1 !== 3) begin failures++; $display("FAIL k_exit_latency_p1 got=%0d want=3", t1); end
    checks++; if (t2 !== 4) begin failures++; $display("FAIL k_exit_latency_p2 got=%0d want=4", t2); end
    checks++; if (sum1 !== 64'd0 || count1 !== 32'd0) begin failures++; $display("FAIL k_exit_p1 got=%0d/%0d want=0/0", sum1, count1); end
    checks++; if (sum2 !== 64'd999 || count2 !== 32'd1) begin failures++; $display("FAIL k_exit_p2 got=%0d/%0d want=999/1", sum2, count2); end
    consume();
  endtask

  task automatic test_empty_and_single;
    int t1, t2;
    start_req(32'd5, 32'd3);
    wait_done(t1, t2);
    checks++; if (t1 !== 0) begin failures++; $display("FAIL empty_latency got=%0d want=0", t1); end
    checks++; if (sum1 !== 64'd0 || count1 !== 32'd0) begin failures++; $display("FAIL empty_data got=%0d/%0d want=0/0", sum1, count1); end
    consume();
    start_req(32'd7, 32'd7);
    wait_done(t1, t2);
    checks++; if (t1 !== 3 || t2 !== 3) begin failures++; $display("FAIL single_latency got=%0d/%0d want=3/3", t1, t2); end
    checks++; if (sum2 !== 64'd0 || count2 !== 32'd0) begin failures++; $display("FAIL single_data got=%0d/%0d want=0/0", sum2, count2); end
    consume();
  endtask

  task automatic test_backpressure;
    int t1, t2;
    start_req(32'd11, 32'd22);
    wait_done(t1, t2);
    in_valid = 1'b1;
    lo_in    = 32'd22;
    hi_in    = 32'd22;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      checks++;
      if (out_valid1 !== 1'b1 || sum1 !== 64'd33 || count1 !== 32'd2 || in_ready1 !== 1'b0) begin
        failures++;
        $display("FAIL hold_cycle%0d got v=%b s=%0d c=%0d r=%b want v=1 s=33 c=2 r=0", i, out_valid1, sum1, count1, in_ready1);
      end
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    checks++; if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0) begin failures++; $display("FAIL release_idle got r=%b v=%b want r=1 v=0", in_ready1, out_valid1); end
    @(posedge clock); #1;
    in_valid = 1'b0;
    checks++; if (busy1 !== 1'b1 || busy2 !== 1'b1) begin failures++; $display("FAIL accept_after_release got=%b%b want=11", busy1, busy2); end
    wait_done(t1, t2);
    checks++; if (sum1 !== 64'd22 || count1 !== 32'd1) begin failures++; $display("FAIL queued_p1 got=%0d/%0d want=22/1", sum1, count1); end
    checks++; if (sum2 !== 64'd22 || count2 !== 32'd1) begin failures++; $display("FAIL queued_p2 got=%0d/%0d want=22/1", sum2, count2); end
    consume();
  endtask

  task automatic test_reset_mid_scan;
    int t1, t2;
    start_req(32'd11, 32'd22);
    repeat (10) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (busy1 !== 1'b0 || out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin failures++; $display("FAIL midreset_ctrl got b=%b v=%b r=%b want 0 0 1", busy1, out_valid1, in_ready1); end
    checks++; if (sum1 !== 64'd0 || count1 !== 32'd0) begin failures++; $display("FAIL midreset_data got=%0d/%0d want=0/0", sum1, count1); end
    @(posedge clock); #1;
    reset_n = 1'b1;
    start_req(32'd1188511880, 32'd1188511890);
    wait_done(t1, t2);
    checks++; if (t1 < 0 || t2 < 0) begin failures++; $display("FAIL big_timeout got=%0d/%0d want>=0", t1, t2); end
    checks++; if (sum1 !== 64'd1188511885 || count1 !== 32'd1) begin failures++; $display("FAIL big_p1 got=%0d/%0d want=1188511885/1", sum1, count1); end
    checks++; if (sum2 !== 64'd1188511885 || count2 !== 32'd1) begin failures++; $display("FAIL big_p2 got=%0d/%0d want=1188511885/1", sum2, count2); end
    consume();
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    lo_in     = '0;
    hi_in     = '0;
    #23;
    test_reset();
    @(posedge clock); #1;
    reset_n = 1'b1;
    test_basic_range();
    test_mixed_range();
    test_digit_boundary();
    test_empty_and_single();
    test_backpressure();
    test_reset_mid_scan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/range_scan_ctrl.md
Name: range_scan_ctrl

Overview:
- Sequencer that accepts an ID range [lo_in, hi_in] and walks every n in that range.
- For each n it computes the digit count, then time-shares a single repeated-group checker across candidate group counts k.
- It accumulates the sum and count of IDs that are made of k identical digit groups, and returns the totals through a valid/ready result port.
- It sits between the puzzle-input streamer and the answer collector, and replaces the fixed one-k-per-instance checking scheme.

Parameters:
DATA_WIDTH, 32, width of lo/hi/n; matches `DATA_WIDTH.
LONG_DATA_WIDTH, 64, width of sum accumulator; matches `LONG_DATA_WIDTH.
MAX_DIGS, 10, maximum decimal digits in n; sizes the power-of-ten table and the k counter.
PART, 1, 1 = test k=2 only; 2 = test every k in 2..digs.

Ports:
clock  in  1  system clock, rising edge.
reset_n  in  1  asynchronous, active-low reset.
in_valid  in  1  range request valid.
in_ready  out  1  high only in IDLE.
lo_in  in  DATA_WIDTH  first ID of range, inclusive.
hi_in  in  DATA_WIDTH  last ID of range, inclusive.
out_valid  out  1  result valid; held until out_ready.
out_ready  in  1  result accepted.
sum_out  out  LONG_DATA_WIDTH  sum of matching IDs, modulo 2^LONG_DATA_WIDTH.
count_out  out  DATA_WIDTH  number of matching IDs.
busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - n, hi, k, digs, sum, count cleared.
  - in_ready=1, out_valid=0, busy=0, sum_out=0, count_out=0.
  - Reset asserted mid-scan aborts the scan with no output.
- Handshakes:
  - Request is accepted on the edge where in_valid && in_ready. lo/hi are registered, sum/count are cleared, and n is set to lo.
  - Result: out_valid stays high with sum_out/count_out stable until an edge with out_ready=1, then IDLE. Back-pressure has no limit.
- FSM:
  - IDLE: on accept, go to DIGS if lo<=hi, else DONE (sum=0, count=0).
  - DIGS (1 cycle): digs = decimal digit count of n (n=0 counts as 1 digit); k=2.
  - CHECK (1 cycle per k): the checker is evaluated for (n, digs, k).
    - A match sets the hit flag and goes to NEXT.
    - No match: if k == limit go to NEXT, else k++.
    - limit = 2 when PART=1; limit = max(digs,2) when PART=2.
  - NEXT (1 cycle):
    - If hit: sum += n (zero-extended), count++.
    - Clear hit.
    - If n==hi go to DONE, else n++ and go to DIGS.
    - The range ends on the equality test, so hi = all-ones terminates without wrap.
  - DONE: out_valid=1 until consumed.
- Per-n latency is 2 + (number of k tested). The accepting edge is counted as edge 0.
- Checker rule (combinational): match iff k divides digs, digs>=2, and n == chunk * R.
  - L = digs/k.
  - chunk = n mod 10^L, and chunk >= 10^(L-1), i.e. no leading zero.
  - R = sum over i<k of 10^(i*L).
  - A non-divisor k returns no match. It still costs its cycle.
- Width rules:
  - Products are computed at LONG_DATA_WIDTH.
  - The power table holds 10^0..10^MAX_DIGS at LONG_DATA_WIDTH.
  - sum wraps modulo 2^LONG_DATA_WIDTH. count wraps modulo 2^DATA_WIDTH; no saturation.
- in_valid while busy is ignored (in_ready=0). out_ready outside DONE is ignored.

Decomposition:
- Shared package holds:
  - the DATA_WIDTH/LONG_DATA_WIDTH constants;
  - the state enum (IDLE, DIGS, CHECK, NEXT, DONE);
  - the pow10 table function;
  - the digit-count function used by DIGS.
- One sub-module: group_match. It is combinational: inputs n, digs, k; output match. It holds the divisibility test and the chunk/R comparison, so it can be verified standalone.

Test Plan:
- PART=1, range 11..22 -> sum_out=33, count_out=2. out_valid rises at edge 36 (12 IDs x 3 cycles).
- PART=1 and PART=2, range 95..115 -> PART=1: sum=99, count=1. PART=2: sum=210 (99+111), count=2.
- PART=2, range 998..1012 -> sum=2009 (999+1010), count=2. For n=999, CHECK exits at k=3 after 2 cycles.
- lo=5, hi=3 -> out_valid one cycle after accept, with sum=0, count=0. Range 7..7 -> sum=0 after 3 cycles.
- out_ready held low for 10 cycles in DONE -> out_valid and data stable, in_ready=0. A new request while busy is not accepted. It is accepted the cycle after the result is consumed.
- reset_n pulsed low mid-scan of 11..22 -> all outputs zero immediately. A new range 1188511880..1188511890 in PART=1 then gives sum=1188511885, count=1.
